// File: rtl/id_ex_issue_stage_if.sv
// Decode-side, ALU-side and forwarding signals of the ID/EX issue stage.
// master: decode/ALU/forwarding environment; slave: the issue stage itself.
interface id_ex_issue_stage_if #(
   parameter int DATA_W = 24,
   parameter int OP_W   = 5,
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic              id_ready;
   logic [OP_W-1:0]   id_op;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;
   logic              id_reg_write;
   logic              id_mem_read;

   logic              ex_valid;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [OP_W-1:0]   ex_op;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;

   logic              mem_fwd_valid;
   logic [REG_AW-1:0] mem_fwd_rd;
   logic [DATA_W-1:0] mem_fwd_data;
   logic              wb_fwd_valid;
   logic [REG_AW-1:0] wb_fwd_rd;
   logic [DATA_W-1:0] wb_fwd_data;

   modport master (
      output id_valid, id_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
             id_imm, id_use_imm, id_reg_write, id_mem_read, ex_ready,
             mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
             wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
      input  id_ready, ex_valid, ex_a, ex_b, ex_op, ex_rd, ex_reg_write,
             ex_mem_read
   );

   modport slave (
      input  id_valid, id_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
             id_imm, id_use_imm, id_reg_write, id_mem_read, ex_ready,
             mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
             wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
      output id_ready, ex_valid, ex_a, ex_b, ex_op, ex_rd, ex_reg_write,
             ex_mem_read
   );
endinterface

// File: rtl/id_ex_issue_stage.sv
// ID/EX issue register: operand forwarding (MEM > WB > regfile), load-use bubbles, flush.
// Optional macro STALL_CNT_EN adds a saturating stall_cnt output.
module id_ex_issue_stage #(
   parameter int DATA_W = 24,
   parameter int OP_W   = 5,
   parameter int REG_AW = 5
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush,
   id_ex_issue_stage_if.slave bus
`ifdef STALL_CNT_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);

   function automatic logic [DATA_W-1:0] fwd_pick(
      input logic [REG_AW-1:0] idx,
      input logic [DATA_W-1:0] dflt,
      input logic              mv,
      input logic [REG_AW-1:0] mrd,
      input logic [DATA_W-1:0] md,
      input logic              wv,
      input logic [REG_AW-1:0] wrd,
      input logic [DATA_W-1:0] wd
   );
      if (idx == '0)
         return '0;
      if (mv && (mrd == idx))
         return md;
      if (wv && (wrd == idx))
         return wd;
      return dflt;
   endfunction

   logic              vld_p1;
   logic [DATA_W-1:0] a_p1;
   logic [DATA_W-1:0] b_p1;
   logic [OP_W-1:0]   op_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [REG_AW-1:0] rs_p1;
   logic [REG_AW-1:0] rt_p1;
   logic              use_imm_p1;
   logic              reg_write_p1;
   logic              mem_read_p1;

   logic              hazard;
   logic              ready;
   logic              capture;
   logic              hold;
   logic [DATA_W-1:0] a_cap;
   logic [DATA_W-1:0] b_cap;
   logic [DATA_W-1:0] a_snoop;
   logic [DATA_W-1:0] b_snoop;

   always_comb begin
      hazard  = vld_p1 & mem_read_p1 & reg_write_p1 & (rd_p1 != '0) &
                ((rd_p1 == bus.id_rs) | (~bus.id_use_imm & (rd_p1 == bus.id_rt)));
      ready   = ~flush & ~hazard & (~vld_p1 | bus.ex_ready);
      capture = bus.id_valid & ready;
      hold    = vld_p1 & ~bus.ex_ready & ~flush;
   end

   // Operands for a fresh capture and for re-snooping a held entry
   always_comb begin
      a_cap   = fwd_pick(bus.id_rs, bus.id_rs_data,
                         bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data,
                         bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
      b_cap   = bus.id_use_imm ? bus.id_imm :
                fwd_pick(bus.id_rt, bus.id_rt_data,
                         bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data,
                         bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
      a_snoop = fwd_pick(rs_p1, a_p1,
                         bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data,
                         bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
      b_snoop = use_imm_p1 ? b_p1 :
                fwd_pick(rt_p1, b_p1,
                         bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data,
                         bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
   end

   // ---- stage p1: registered ALU inputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         a_p1         <= '0;
         b_p1         <= '0;
         op_p1        <= '0;
         rd_p1        <= '0;
         rs_p1        <= '0;
         rt_p1        <= '0;
         use_imm_p1   <= 1'b0;
         reg_write_p1 <= 1'b0;
         mem_read_p1  <= 1'b0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (capture) begin
         vld_p1       <= 1'b1;
         a_p1         <= a_cap;
         b_p1         <= b_cap;
         op_p1        <= bus.id_op;
         rd_p1        <= bus.id_rd;
         rs_p1        <= bus.id_rs;
         rt_p1        <= bus.id_rt;
         use_imm_p1   <= bus.id_use_imm;
         reg_write_p1 <= bus.id_reg_write;
         mem_read_p1  <= bus.id_mem_read;
      end else if (hold) begin
         // Producers may retire while we wait; pick up their results
         a_p1 <= a_snoop;
         b_p1 <= b_snoop;
      end else begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.id_ready     = ready;
   assign bus.ex_valid     = vld_p1;
   assign bus.ex_a         = a_p1;
   assign bus.ex_b         = b_p1;
   assign bus.ex_op        = op_p1;
   assign bus.ex_rd        = rd_p1;
   assign bus.ex_reg_write = reg_write_p1;
   assign bus.ex_mem_read  = mem_read_p1;

`ifdef STALL_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (bus.id_valid & ~ready & ~flush)
         stall_cnt <= sat_inc(stall_cnt);
   end
`endif

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Randomized and directed bench for id_ex_issue_stage against a transaction-level model.
// Define STALL_CNT_EN to also cover the stall counter.
module tb_id_ex_issue_stage;
   localparam int DATA_W = 24;
   localparam int OP_W   = 5;
   localparam int REG_AW = 5;

   logic clk;
   logic rst_n;
   logic flush;
`ifdef STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   id_ex_issue_stage_if #(.DATA_W(DATA_W), .OP_W(OP_W), .REG_AW(REG_AW)) bus ();

   id_ex_issue_stage #(.DATA_W(DATA_W), .OP_W(OP_W), .REG_AW(REG_AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
`ifdef STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit                v;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      bit                use_imm;
      bit                rw;
      bit                mr;
   } entry_t;

   entry_t      m;
   int unsigned m_cnt;
   int unsigned n_checks;
   int unsigned n_fail;
   logic        obs_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Newest in-flight producer of register idx, if any (MEM is younger than WB)
   function automatic bit newest_producer(input logic [REG_AW-1:0] idx,
                                          output logic [DATA_W-1:0] val);
      val = '0;
      if (idx == 0) return 1'b0;
      if (bus.mem_fwd_valid && bus.mem_fwd_rd == idx) begin val = bus.mem_fwd_data; return 1'b1; end
      if (bus.wb_fwd_valid && bus.wb_fwd_rd == idx) begin val = bus.wb_fwd_data; return 1'b1; end
      return 1'b0;
   endfunction

   function automatic logic [DATA_W-1:0] arch_value(input logic [REG_AW-1:0] idx,
                                                    input logic [DATA_W-1:0] regval);
      logic [DATA_W-1:0] p;
      if (idx == 0) return '0;
      if (newest_producer(idx, p)) return p;
      return regval;
   endfunction

   function automatic bit model_ready();
      bit load_use;
      load_use = m.v && m.mr && m.rw && (m.rd != 0) &&
                 ((m.rd == bus.id_rs) || (!bus.id_use_imm && m.rd == bus.id_rt));
      return !flush && !load_use && (!m.v || bus.ex_ready);
   endfunction

   task automatic model_advance(input bit rdy);
      logic [DATA_W-1:0] p;
      if (bus.id_valid && !rdy && !flush && m_cnt < 32'hFFFF) m_cnt++;
      if (flush) begin
         m.v = 1'b0;
      end else if (bus.id_valid && rdy) begin
         m.v       = 1'b1;
         m.a       = arch_value(bus.id_rs, bus.id_rs_data);
         m.b       = bus.id_use_imm ? bus.id_imm : arch_value(bus.id_rt, bus.id_rt_data);
         m.op      = bus.id_op;
         m.rd      = bus.id_rd;
         m.rs      = bus.id_rs;
         m.rt      = bus.id_rt;
         m.use_imm = bus.id_use_imm;
         m.rw      = bus.id_reg_write;
         m.mr      = bus.id_mem_read;
      end else if (m.v && !bus.ex_ready) begin
         if (newest_producer(m.rs, p)) m.a = p;
         if (!m.use_imm && newest_producer(m.rt, p)) m.b = p;
      end else begin
         m.v = 1'b0;
      end
   endtask

   // Inputs are set at posedge+1; id_ready is sampled mid-cycle, outputs at next posedge+1
   task automatic step();
      bit exp_rdy;
      #4;
      exp_rdy   = model_ready();
      obs_ready = bus.id_ready;
      check("id_ready", {31'd0, obs_ready}, {31'd0, exp_rdy});
      model_advance(exp_rdy);
      @(posedge clk);
      #1;
      check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m.v});
      if (m.v) begin
         check("ex_a", {8'd0, bus.ex_a}, {8'd0, m.a});
         check("ex_b", {8'd0, bus.ex_b}, {8'd0, m.b});
         check("ex_op", {27'd0, bus.ex_op}, {27'd0, m.op});
         check("ex_rd", {27'd0, bus.ex_rd}, {27'd0, m.rd});
         check("ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, m.rw});
         check("ex_mem_read", {31'd0, bus.ex_mem_read}, {31'd0, m.mr});
      end
`ifdef STALL_CNT_EN
      check("stall_cnt", {16'd0, stall_cnt}, m_cnt);
`endif
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_valid"}, {31'd0, bus.ex_valid}, 32'd0);
      check({tag, "_a"}, {8'd0, bus.ex_a}, 32'd0);
      check({tag, "_b"}, {8'd0, bus.ex_b}, 32'd0);
      check({tag, "_op"}, {27'd0, bus.ex_op}, 32'd0);
      check({tag, "_rd"}, {27'd0, bus.ex_rd}, 32'd0);
      check({tag, "_rw"}, {31'd0, bus.ex_reg_write}, 32'd0);
      check({tag, "_mr"}, {31'd0, bus.ex_mem_read}, 32'd0);
`ifdef STALL_CNT_EN
      check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
`endif
   endtask

   task automatic idle();
      bus.id_valid      = 1'b0;
      bus.id_op         = '0;
      bus.id_rs         = '0;
      bus.id_rt         = '0;
      bus.id_rd         = '0;
      bus.id_rs_data    = '0;
      bus.id_rt_data    = '0;
      bus.id_imm        = '0;
      bus.id_use_imm    = 1'b0;
      bus.id_reg_write  = 1'b0;
      bus.id_mem_read   = 1'b0;
      bus.ex_ready      = 1'b1;
      bus.mem_fwd_valid = 1'b0;
      bus.mem_fwd_rd    = '0;
      bus.mem_fwd_data  = '0;
      bus.wb_fwd_valid  = 1'b0;
      bus.wb_fwd_rd     = '0;
      bus.wb_fwd_data   = '0;
      flush             = 1'b0;
   endtask

   task automatic offer(input logic [OP_W-1:0] op, input logic [REG_AW-1:0] rs,
                        input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                        input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                        input bit use_imm, input bit rw, input bit mr);
      bus.id_valid     = 1'b1;
      bus.id_op        = op;
      bus.id_rs        = rs;
      bus.id_rt        = rt;
      bus.id_rd        = rd;
      bus.id_rs_data   = rsd;
      bus.id_rt_data   = rtd;
      bus.id_imm       = 24'hFFFFF0;
      bus.id_use_imm   = use_imm;
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m        = '{default: '0};
      m_cnt    = 0;
      rst_n    = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;

      // Basic issue
      offer(5'b00011, 5'd1, 5'd2, 5'd3, 24'h000010, 24'h000020, 1'b0, 1'b1, 1'b0);
      step();
      check("basic_a", {8'd0, bus.ex_a}, 32'h000010);
      check("basic_b", {8'd0, bus.ex_b}, 32'h000020);
      check("basic_op", {27'd0, bus.ex_op}, 32'h3);

      // Forward priority, then r0 never forwards
      offer(5'd4, 5'd3, 5'd2, 5'd5, 24'h000111, 24'h000222, 1'b0, 1'b1, 1'b0);
      bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd3; bus.mem_fwd_data = 24'hAAAAAA;
      bus.wb_fwd_valid  = 1'b1; bus.wb_fwd_rd  = 5'd3; bus.wb_fwd_data  = 24'h555555;
      step();
      check("fwd_prio_a", {8'd0, bus.ex_a}, 32'hAAAAAA);
      bus.id_rs = 5'd0; bus.mem_fwd_rd = 5'd0; bus.wb_fwd_rd = 5'd0;
      step();
      check("fwd_r0_a", {8'd0, bus.ex_a}, 32'h0);

      // Load-use bubble, then accept via MEM forward
      idle();
      offer(5'h10, 5'd1, 5'd2, 5'd4, 24'h0, 24'h0, 1'b1, 1'b1, 1'b1);
      step();
      offer(5'd6, 5'd4, 5'd5, 5'd7, 24'h000BAD, 24'h000001, 1'b0, 1'b1, 1'b0);
      step();
      check("lu_ready", {31'd0, obs_ready}, 32'd0);
      check("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
      bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd4; bus.mem_fwd_data = 24'h000007;
      step();
      check("lu_accept", {31'd0, obs_ready}, 32'd1);
      check("lu_a", {8'd0, bus.ex_a}, 32'h000007);

      // Hold with re-snoop of rt
      idle();
      offer(5'd9, 5'd0, 5'd6, 5'd8, 24'h0, 24'h000111, 1'b0, 1'b1, 1'b0);
      step();
      bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
      step();
      bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd6; bus.wb_fwd_data = 24'h123456;
      step();
      bus.wb_fwd_valid = 1'b0;
      step();
      check("hold_b", {8'd0, bus.ex_b}, 32'h123456);
      check("hold_op", {27'd0, bus.ex_op}, 32'd9);
      check("hold_valid", {31'd0, bus.ex_valid}, 32'd1);
      bus.ex_ready = 1'b1;
      step();
      check("hold_consumed", {31'd0, bus.ex_valid}, 32'd0);

      // Flush while holding with an incoming offer
      offer(5'd2, 5'd1, 5'd1, 5'd1, 24'h5, 24'h5, 1'b0, 1'b1, 1'b0);
      step();
      bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
      step();
      flush = 1'b1; bus.id_valid = 1'b1;
      step();
      check("flush_ready", {31'd0, obs_ready}, 32'd0);
      check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
      idle();
      step();
      check("flush_nocap", {31'd0, bus.ex_valid}, 32'd0);

      // Async reset during a hold
      offer(5'd11, 5'd1, 5'd2, 5'd3, 24'h9, 24'h8, 1'b0, 1'b1, 1'b1);
      step();
      bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      m = '{default: '0};
      m_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      offer(5'd12, 5'd2, 5'd0, 5'd9, 24'h000042, 24'h0, 1'b0, 1'b1, 1'b0);
      bus.ex_ready = 1'b0;
      step();
      check("post_rst_a", {8'd0, bus.ex_a}, 32'h42);
      repeat (3) step();
`ifdef STALL_CNT_EN
      check("stall_three", {16'd0, stall_cnt}, 32'd3);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.id_valid      = ($urandom_range(0, 3) != 0);
         bus.id_op         = OP_W'($urandom);
         bus.id_rs         = REG_AW'($urandom_range(0, 7));
         bus.id_rt         = REG_AW'($urandom_range(0, 7));
         bus.id_rd         = REG_AW'($urandom_range(0, 7));
         bus.id_rs_data    = DATA_W'($urandom);
         bus.id_rt_data    = DATA_W'($urandom);
         bus.id_imm        = DATA_W'($urandom);
         bus.id_use_imm    = ($urandom_range(0, 2) == 0);
         bus.id_reg_write  = ($urandom_range(0, 3) != 0);
         bus.id_mem_read   = ($urandom_range(0, 2) == 0);
         bus.ex_ready      = ($urandom_range(0, 3) != 0);
         bus.mem_fwd_valid = ($urandom_range(0, 1) == 0);
         bus.mem_fwd_rd    = REG_AW'($urandom_range(0, 7));
         bus.mem_fwd_data  = DATA_W'($urandom);
         bus.wb_fwd_valid  = ($urandom_range(0, 1) == 0);
         bus.wb_fwd_rd     = REG_AW'($urandom_range(0, 7));
         bus.wb_fwd_data   = DATA_W'($urandom);
         flush             = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
- Pipeline register between decode and the 24-bit ALU.
- Captures decoded instructions and resolves operands A/B using forwarding from the MEM and WB stages, then presents registered operands and the 5-bit opcode to the ALU.
- Detects load-use hazards and inserts bubbles.
- Provides a valid/ready handshake on both sides, plus flush.

Parameters:
DATA_W, 24, operand/result width
OP_W, 5, ALU opcode width
REG_AW, 5, register index width (r0 hard-wired zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode offers instruction
id_ready  out  1  stage accepts instruction this cycle
id_op  in  OP_W  ALU opcode
id_rs  in  REG_AW  source A index
id_rt  in  REG_AW  source B index
id_rd  in  REG_AW  destination index
id_rs_data  in  DATA_W  regfile value of rs
id_rt_data  in  DATA_W  regfile value of rt
id_imm  in  DATA_W  sign-extended immediate
id_use_imm  in  1  B = immediate; rt not a source
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
flush  in  1  kill held and incoming instruction
ex_valid  out  1  ALU inputs valid
ex_ready  in  1  downstream consumes entry
ex_a  out  DATA_W  ALU operand A
ex_b  out  DATA_W  ALU operand B
ex_op  out  OP_W  ALU opcode
ex_rd  out  REG_AW  destination
ex_reg_write  out  1  writes rd
ex_mem_read  out  1  load
mem_fwd_valid  in  1  MEM stage result forwardable
mem_fwd_rd  in  REG_AW  MEM destination
mem_fwd_data  in  DATA_W  MEM result
wb_fwd_valid  in  1  WB stage writing regfile
wb_fwd_rd  in  REG_AW  WB destination
wb_fwd_data  in  DATA_W  WB data

Behaviour:
- Reset (async, rst_n=0): ex_valid, ex_a, ex_b, ex_op, ex_rd, ex_reg_write, ex_mem_read all 0.
- Single entry. Outputs are registered, so latency id→ex is 1 cycle.
- Hazard: ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs | (!id_use_imm & ex_rd==id_rt)).
- id_ready = !flush & !hazard & (!ex_valid | ex_ready).
- Capture (id_valid & id_ready): all fields load next edge; ex_valid=1.
- Operand resolve at capture, priority MEM > WB > regfile data:
  - A uses rs.
  - B uses rt, or id_imm when id_use_imm=1.
  - Index 0 never forwards; it always yields 0.
- Hazard with ex_ready=1: entry drains, ex_valid=0 (bubble) next cycle. The instruction is accepted on a later cycle, when the load has moved to MEM and forwards via mem_fwd.
- Hold (ex_valid & !ex_ready & !flush): op, rd and flags are frozen. Operand registers re-snoop: the held source index (stored internally as rs/rt/use_imm) is compared to mem_fwd and wb_fwd each cycle, and the operand is overwritten on a hit (MEM > WB). This keeps the entry correct after a producer retires.
- Drain without capture (ex_ready & ex_valid, no id handshake): ex_valid=0 next cycle. Data fields are don't-care but hold their last values.
- Flush: synchronous. ex_valid=0 next edge regardless of ex_ready; no capture that cycle. Flush has priority over capture and hold.
- Reset mid-operation: entry discarded immediately; the first id handshake after rst_n rises is accepted normally.

Optional Feature:
STALL_CNT_EN
- Defined: adds output stall_cnt [15:0], counting cycles with id_valid & !id_ready & !flush. Saturates at 16'hFFFF; async-reset to 0.
- Undefined: port and counter absent; no other change.

Test Plan:
- Basic issue: id op=5'b00011, rs_data=24'h000010, rt_data=24'h000020 (no forward hits), ex_ready=1 → next cycle ex_valid=1, ex_a=24'h000010, ex_b=24'h000020, ex_op=5'b00011.
- Forward priority: id_rs=3, mem_fwd rd=3 data=24'hAAAAAA, wb_fwd rd=3 data=24'h555555 → ex_a=24'hAAAAAA. Same with rs=0 → ex_a=0.
- Load-use: load to r4 held in stage, id_rs=4 → id_ready=0, ex_valid=0 the following cycle. Next cycle mem_fwd rd=4 data=24'h000007 → instruction accepted, ex_a=24'h000007.
- Hold with re-snoop: ex_ready=0 for 3 cycles with held rt=6; wb_fwd rd=6 data=24'h123456 in cycle 2 → ex_b=24'h123456 and ex_op unchanged; release ex_ready → consumed once.
- Flush: flush=1 while ex_valid=1, ex_ready=0 and id_valid=1 → ex_valid=0 next cycle, id_ready=0 during flush, no capture.
- Reset: assert rst_n=0 mid-hold → all outputs 0 immediately. With STALL_CNT_EN, stall_cnt=0 and increments once per stalled cycle afterward.
